fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RV32I core. It replaces the bare PC register plus +4 adder with a PC sequencer that talks to instruction memory over a request/response handshake. Fetched words go into a DEPTH-entry FIFO with their PC, which lets decode stall independently of memory latency. Redirects from jump/branch resolution flush the FIFO and discard any in-flight response.

## Interface
- XLEN, 32, address/instruction width (32 only in this generation; kept for the RV64 path)
- RESET_VECTOR, 32'h0000_0000, PC fetched first after reset
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- reset_pc_n  in  1  synchronous, active-low reset
- req_valid  out  1  fetch request
- req_addr  out  XLEN  fetch address (word aligned)
- req_ready  in  1  memory accepts request this cycle
- resp_valid  in  1  instruction word returned
- resp_instr  in  32  returned instruction
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode consumes head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  32  head instruction
- redirect_valid  in  1  jump/branch taken
- redirect_pc  in  XLEN  new fetch PC
- fault  out  1  misaligned redirect; fetch halted

## Operation
- Registers: fetch_pc, state, FIFO (pc+instr per entry), rd/wr pointers, count (0..DEPTH).
- States: S_REQ, S_WAIT, S_DROP, S_FAULT. At most one request outstanding.
- S_REQ: req_valid = (count < DEPTH) && !redirect_valid; req_addr = fetch_pc. On req_valid && req_ready: fetch_pc += 4 (mod 2^XLEN, wraps), go to S_WAIT.
- S_WAIT: on resp_valid, push {req PC, resp_instr} and go to S_REQ. Space is guaranteed because issue required count < DEPTH.
- S_DROP: on resp_valid, discard the word and go to S_REQ.
- S_FAULT: no requests; fault = 1; only an aligned redirect exits.
- Redirect (highest priority, any state):
  - Flush the FIFO (count, pointers to 0).
  - If redirect_pc[1:0] == 0: set fetch_pc = redirect_pc. Next state is S_DROP if in S_WAIT/S_DROP without resp_valid this cycle, otherwise S_REQ.
  - If redirect_pc[1:0] != 0: go to S_FAULT; fetch_pc is unchanged. A response in flight is still absorbed: S_FAULT drops any resp_valid.
- Pop: on out_valid && out_ready. A pop in the redirect cycle counts as consumed, then the flush applies.
- Push and pop in the same cycle leave count unchanged.
- req_valid may deassert without acceptance (redirect or reset). Memory must not latch an unaccepted request.
- resp_valid outside S_WAIT/S_DROP/S_FAULT is illegal. It is ignored, and the bench flags it.

## Timing
- Reset (reset_pc_n = 0 at edge):
  - state = S_REQ, fetch_pc = RESET_VECTOR, count = 0, fault = 0.
  - During reset cycles: req_valid = 0, out_valid = 0, req_addr = RESET_VECTOR.
  - Reset mid-request abandons the transaction. Memory is reset together with the fetch unit.
- First request is combinationally valid in the first cycle after reset release (cycle 0).
- Zero-wait memory (req_ready = 1, response in cycle N+1): push at the end of N+1; out_valid high in N+2. Throughput is 1 instruction per 2 cycles.
- out_* are driven straight from registered FIFO state, with no combinational path from out_ready.
- Redirect at edge E: out_valid = 0 and fault updated from E+1. A new request at redirect_pc issues at E+1 if in S_REQ.
- FIFO full (count = DEPTH): req_valid held 0 until a pop. Issue resumes the cycle after the pop.

## Test plan
- Reset/stream:
  - Stimulus: RESET_VECTOR = 0, zero-wait memory returning addr as data, out_ready = 1.
  - Required: out_pc sequence 0,4,8,12 with out_instr = out_pc; first out_valid at cycle 2.
- Backpressure:
  - Stimulus: DEPTH = 4, out_ready = 0.
  - Required: exactly 4 requests (0..12), then req_valid = 0. Raising out_ready drains 0,4,8,12 in order and fetch resumes at 16.
- Redirect during wait:
  - Stimulus: request to 0x8 accepted, redirect_pc = 0x100 before the response.
  - Required: the 0x8 response is discarded, the next req_addr is 0x100, and out_pc 0x100 is the first output after the flush.
- Redirect with simultaneous response and pop:
  - Stimulus: resp_valid, out_ready and redirect_valid (0x40) in one cycle.
  - Required: head popped, response discarded, FIFO empty at E+1, next request 0x40.
- Misaligned redirect:
  - Stimulus: redirect_pc = 0x102.
  - Required: fault = 1, no req_valid. Then redirect_pc = 0x104 gives fault = 0 and a request to 0x104 the next cycle.
- Wrap:
  - Stimulus: RESET_VECTOR = 32'hFFFF_FFF8.
  - Required: req_addr sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundle of the fetch front-end's buses: instruction-memory
//                request/response, decode-side FIFO head, redirect input and
//                the fault flag.
//                master : fetch_unit side (drives req_*, out_*, fault)
//                slave  : memory/decode/branch side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
) ();
    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            req_ready;
    logic            resp_valid;
    logic [31:0]     resp_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fault;

    modport master (
        output req_valid, req_addr, out_valid, out_pc, out_instr, fault,
        input  req_ready, resp_valid, resp_instr, out_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_pc, out_instr, fault,
        output req_ready, resp_valid, resp_instr, out_ready,
               redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : RV32I instruction-fetch front end. A PC sequencer issues one
//                outstanding request at a time to instruction memory and
//                pushes returned words, tagged with their PC, into a
//                DEPTH-entry FIFO read by decode. Redirects flush the FIFO and
//                discard any in-flight response; a misaligned redirect halts
//                fetch and raises fault until an aligned redirect arrives.
//  Ports       : clk        - clock, all state on rising edge
//                reset_pc_n - synchronous active-low reset
//                bus        - fetch_unit_if.master (memory, decode, redirect)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              DEPTH        = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_pc_n,
    fetch_unit_if.master    bus
);

    localparam int                c_PTR_W   = $clog2(DEPTH);
    localparam int                c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH  = c_CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]   c_PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     w_fetch_pc_nxt;
    logic [XLEN-1:0]     r_req_pc;      // PC of the outstanding request
    logic [XLEN-1:0]     r_fifo_pc    [DEPTH];
    logic [31:0]         r_fifo_instr [DEPTH];
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic w_aligned;
    logic w_req_valid;
    logic w_issue;
    logic w_out_valid;
    logic w_pop;
    logic w_push;
    logic w_in_flight;

    assign w_aligned   = (bus.redirect_pc[1:0] == 2'b00);
    // Outputs are forced quiet while reset is asserted, even before the
    // registers have taken their reset values.
    assign w_req_valid = reset_pc_n && (r_state == S_REQ) &&
                         (r_count < c_DEPTH) && !bus.redirect_valid;
    assign w_issue     = w_req_valid && bus.req_ready;
    assign w_out_valid = reset_pc_n && (r_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    // A response landing in the redirect cycle belongs to the old stream.
    assign w_push      = reset_pc_n && (r_state == S_WAIT) &&
                         bus.resp_valid && !bus.redirect_valid;
    assign w_in_flight = (r_state == S_WAIT) || (r_state == S_DROP);

    // ------------------------------------------------------------------
    // Next-state / next-PC
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        case (r_state)
            S_REQ: begin
                if (w_issue) begin
                    w_state_nxt    = S_WAIT;
                    w_fetch_pc_nxt = r_fetch_pc + c_PC_STEP;
                end
            end
            S_WAIT:  if (bus.resp_valid) w_state_nxt = S_REQ;
            S_DROP:  if (bus.resp_valid) w_state_nxt = S_REQ;
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_REQ;
        endcase

        if (bus.redirect_valid) begin
            if (w_aligned) begin
                w_fetch_pc_nxt = bus.redirect_pc;
                // A response still owed by memory must be swallowed before
                // the new stream may issue.
                w_state_nxt = (w_in_flight && !bus.resp_valid) ? S_DROP : S_REQ;
            end else begin
                w_fetch_pc_nxt = r_fetch_pc;
                w_state_nxt    = S_FAULT;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_pc_n) begin
            r_state    <= S_REQ;
            r_fetch_pc <= RESET_VECTOR;
            r_req_pc   <= RESET_VECTOR;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            if (w_issue) r_req_pc <= r_fetch_pc;

            if (bus.redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset: entries are only read once counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_pc;
            r_fifo_instr[r_wr_ptr] <= bus.resp_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_valid = w_req_valid;
    assign bus.req_addr  = reset_pc_n ? r_fetch_pc : RESET_VECTOR;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = r_fifo_pc[r_rd_ptr];
    assign bus.out_instr = r_fifo_instr[r_rd_ptr];
    assign bus.fault     = reset_pc_n && (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: table-driven stream and
//                backpressure vectors, hand sequences for redirect/fault
//                corner cases, a wrap check on a second instance, and a
//                randomized run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus  ();
    fetch_unit_if #(.XLEN(32)) bus2 ();

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset_pc_n(rst_n), .bus(bus)
    );

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .reset_pc_n(rst_n), .bus(bus2)
    );

    // Zero-wait memory for the wrap instance.
    logic r2_resp;
    always @(posedge clk) begin
        if (!rst_n) r2_resp <= 1'b0;
        else        r2_resp <= bus2.req_valid && bus2.req_ready;
    end
    assign bus2.req_ready      = 1'b1;
    assign bus2.resp_valid     = r2_resp;
    assign bus2.resp_instr     = 32'h0;
    assign bus2.out_ready      = 1'b1;
    assign bus2.redirect_valid = 1'b0;
    assign bus2.redirect_pc    = 32'h0;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model for the main instance ----------------
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          mem_lat   = 0;
    bit          rand_ready = 0;
    logic [31:0] salt = 32'h0;

    task automatic drive(input logic ordy, input logic rv, input logic [31:0] rpc);
        bus.out_ready      = ordy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.req_ready      = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.resp_valid     = mem_pend && (mem_delay == 0);
        bus.resp_instr     = bus.resp_valid ? (mem_addr ^ salt) : 32'hDEAD_BEEF;
        #1;
    endtask

    task automatic tick();
        logic        acc;
        logic        rsp;
        logic        in_rst;
        logic [31:0] a;
        acc    = bus.req_valid && bus.req_ready;
        rsp    = bus.resp_valid;
        a      = bus.req_addr;
        in_rst = !rst_n;
        @(posedge clk);
        #1;
        if (in_rst) begin
            mem_pend = 0;
        end else begin
            if (rsp) mem_pend = 0;
            else if (mem_pend && mem_delay > 0) mem_delay--;
            if (acc) begin
                mem_pend  = 1;
                mem_addr  = a;
                mem_delay = mem_lat;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            chk("rst_req_valid", bus.req_valid, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_req_addr",  bus.req_addr, 32'h0);
            chk("rst_fault",     bus.fault, 0);
            chk("rst_wrap_addr", bus2.req_addr, 32'hFFFF_FFF8);
            tick();
        end
        rst_n = 1'b1;
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic        ordy;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(logic o, logic rv, logic [31:0] ad, logic ov, logic [31:0] pc);
        vec_t v;
        v.ordy = o; v.exp_rv = rv; v.exp_addr = ad; v.exp_ov = ov; v.exp_pc = pc;
        return v;
    endfunction

    vec_t stream_tbl [9];
    vec_t bp_tbl     [16];
    logic [31:0] wrap_exp [3];

    task automatic run_vec(input string nm, input vec_t v);
        drive(v.ordy, 1'b0, 32'h0);
        chk({nm, "_req_valid"}, bus.req_valid, v.exp_rv);
        if (v.exp_rv) chk({nm, "_req_addr"}, bus.req_addr, v.exp_addr);
        chk({nm, "_out_valid"}, bus.out_valid, v.exp_ov);
        if (v.exp_ov) begin
            chk({nm, "_out_pc"},    bus.out_pc,    v.exp_pc);
            chk({nm, "_out_instr"}, bus.out_instr, v.exp_pc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    bit          m_pend, m_keep, m_fault;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_tbl[0] = mk(1, 1, 32'h0,  0, 0);
        stream_tbl[1] = mk(1, 0, 0,      0, 0);
        stream_tbl[2] = mk(1, 1, 32'h4,  1, 32'h0);
        stream_tbl[3] = mk(1, 0, 0,      0, 0);
        stream_tbl[4] = mk(1, 1, 32'h8,  1, 32'h4);
        stream_tbl[5] = mk(1, 0, 0,      0, 0);
        stream_tbl[6] = mk(1, 1, 32'hC,  1, 32'h8);
        stream_tbl[7] = mk(1, 0, 0,      0, 0);
        stream_tbl[8] = mk(1, 1, 32'h10, 1, 32'hC);

        bp_tbl[0]  = mk(0, 1, 32'h0,  0, 0);
        bp_tbl[1]  = mk(0, 0, 0,      0, 0);
        bp_tbl[2]  = mk(0, 1, 32'h4,  1, 32'h0);
        bp_tbl[3]  = mk(0, 0, 0,      1, 32'h0);
        bp_tbl[4]  = mk(0, 1, 32'h8,  1, 32'h0);
        bp_tbl[5]  = mk(0, 0, 0,      1, 32'h0);
        bp_tbl[6]  = mk(0, 1, 32'hC,  1, 32'h0);
        bp_tbl[7]  = mk(0, 0, 0,      1, 32'h0);
        bp_tbl[8]  = mk(0, 0, 0,      1, 32'h0);
        bp_tbl[9]  = mk(0, 0, 0,      1, 32'h0);
        bp_tbl[10] = mk(1, 0, 0,      1, 32'h0);
        bp_tbl[11] = mk(1, 1, 32'h10, 1, 32'h4);
        bp_tbl[12] = mk(1, 0, 0,      1, 32'h8);
        bp_tbl[13] = mk(1, 1, 32'h14, 1, 32'hC);
        bp_tbl[14] = mk(1, 0, 0,      1, 32'h10);
        bp_tbl[15] = mk(1, 1, 32'h18, 1, 32'h14);

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        // ---- reset + stream (plus wrap instance running alongside) ----
        salt = 0; mem_lat = 0; rand_ready = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_vec("stream", stream_tbl[i]);
            if ((i % 2 == 0) && (i <= 4)) begin
                chk("wrap_req_valid", bus2.req_valid, 1);
                chk("wrap_req_addr",  bus2.req_addr,  wrap_exp[i / 2]);
            end
            tick();
        end

        // ---- backpressure ----
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_vec("bp", bp_tbl[i]);
            tick();
        end

        // ---- redirect during wait ----
        do_reset();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 0); tick(); end
        mem_lat = 2;
        drive(0, 0, 0);
        chk("rdw_req_valid", bus.req_valid, 1);
        chk("rdw_req_addr",  bus.req_addr, 32'h8);
        tick();
        drive(0, 1, 32'h100);
        chk("rdw_pre_out_valid", bus.out_valid, 1);
        tick();
        drive(0, 0, 0);
        chk("rdw_flush_out_valid", bus.out_valid, 0);
        chk("rdw_drop_req_valid",  bus.req_valid, 0);
        tick();
        drive(0, 0, 0);
        chk("rdw_stale_resp", bus.resp_valid, 1);
        chk("rdw_drop2_req_valid", bus.req_valid, 0);
        tick();
        mem_lat = 0;
        drive(0, 0, 0);
        chk("rdw_new_req_valid", bus.req_valid, 1);
        chk("rdw_new_req_addr",  bus.req_addr, 32'h100);
        tick();
        drive(0, 0, 0); chk("rdw_wait_out_valid", bus.out_valid, 0); tick();
        drive(0, 0, 0);
        chk("rdw_first_out_valid", bus.out_valid, 1);
        chk("rdw_first_out_pc",    bus.out_pc, 32'h100);
        chk("rdw_first_out_instr", bus.out_instr, 32'h100);
        tick();

        // ---- redirect with simultaneous response and pop ----
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 0); tick(); end
        drive(1, 1, 32'h40);
        chk("sim_resp_valid", bus.resp_valid, 1);
        chk("sim_out_valid",  bus.out_valid, 1);
        chk("sim_out_pc",     bus.out_pc, 32'h0);
        tick();
        drive(0, 0, 0);
        chk("sim_flush_out_valid", bus.out_valid, 0);
        chk("sim_req_valid",       bus.req_valid, 1);
        chk("sim_req_addr",        bus.req_addr, 32'h40);
        chk("sim_fault",           bus.fault, 0);
        tick();
        drive(0, 0, 0); tick();
        drive(0, 0, 0);
        chk("sim_next_out_valid", bus.out_valid, 1);
        chk("sim_next_out_pc",    bus.out_pc, 32'h40);
        tick();

        // ---- misaligned redirect ----
        do_reset();
        drive(0, 1, 32'h102);
        chk("mis_req_suppressed", bus.req_valid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0);
            chk("mis_fault",     bus.fault, 1);
            chk("mis_req_valid", bus.req_valid, 0);
            tick();
        end
        drive(0, 1, 32'h104);
        chk("mis_fault_hold", bus.fault, 1);
        tick();
        drive(0, 0, 0);
        chk("mis_fault_clr",  bus.fault, 0);
        chk("mis_req_valid2", bus.req_valid, 1);
        chk("mis_req_addr2",  bus.req_addr, 32'h104);
        tick();
        drive(0, 0, 0); tick();
        drive(0, 0, 0);
        chk("mis_out_pc", bus.out_pc, 32'h104);
        tick();

        // ---- randomized run against the reference model ----
        salt = 32'h1357_9BDF; rand_ready = 1;
        do_reset();
        mq.delete();
        m_pc = 32'h0; m_pend = 0; m_keep = 0; m_fault = 0; m_pend_pc = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        ordy, rv, resp, exp_rv, exp_ov;
            logic [31:0] rpc;
            ordy    = ($urandom_range(0, 3) != 0);
            rv      = ($urandom_range(0, 11) == 0);
            rpc     = 32'($urandom_range(0, 1023)) << 2;
            mem_lat = $urandom_range(0, 3);
            drive(ordy, rv, rpc);
            resp   = bus.resp_valid;
            exp_rv = !m_pend && !m_fault && (mq.size() < 4) && !rv;
            exp_ov = (mq.size() != 0);
            chk("rnd_req_valid", bus.req_valid, exp_rv);
            if (exp_rv) chk("rnd_req_addr", bus.req_addr, m_pc);
            chk("rnd_out_valid", bus.out_valid, exp_ov);
            if (exp_ov) begin
                chk("rnd_out_pc",    bus.out_pc,    mq[0].pc);
                chk("rnd_out_instr", bus.out_instr, mq[0].instr);
            end
            chk("rnd_fault", bus.fault, m_fault);
            chk("rnd_resp_legal", resp && !m_pend && !m_fault, 0);

            if (exp_ov && ordy) void'(mq.pop_front());
            if (rv) begin
                mq.delete();
                if (rpc[1:0] == 2'b00) begin
                    m_pc    = rpc;
                    m_fault = 0;
                    if (m_pend && !resp) m_keep = 0;
                    else                 m_pend = 0;
                end else begin
                    m_fault = 1;
                    m_pend  = 0;
                end
            end else begin
                if (resp && m_pend) begin
                    if (m_keep) mq.push_back('{m_pend_pc, m_pend_pc ^ salt});
                    m_pend = 0;
                end
                if (exp_rv && bus.req_ready) begin
                    m_pend    = 1;
                    m_keep    = 1;
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
